// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the boot/run controller of the MIPS core.
package boot_seq_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_RUN,
    ST_DONE
  } boot_state_t;

  // BREAK with a zero code field is the only instruction that stops a run
  localparam logic [31:0] BREAK_INS   = 32'h0000000D;
  localparam logic [5:0]  OP_SPECIAL  = 6'h00;
  localparam logic [5:0]  FUNCT_BREAK = 6'h0D;

  // Word index to byte address
  localparam int WORD_SHIFT = 2;

  // True only for the exact BREAK encoding (opcode SPECIAL, code 0, funct BREAK)
  function automatic logic is_halt(input logic [31:0] ins);
    return (ins[31:26] == OP_SPECIAL) &&
           (ins[25:6]  == 20'h00000) &&
           (ins[5:0]   == FUNCT_BREAK);
  endfunction

endpackage

// File: rtl/boot_run_counter.sv
// Saturating run-cycle counter with clear/enable and a budget-reached flag.
module boot_run_counter
  import boot_seq_pkg::*;
#(
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CYC_W-1:0] budget,
  output logic [CYC_W-1:0] count,
  output logic             budget_hit
);

  logic [CYC_W-1:0] count_reg;

  // Count enabled cycles, hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != '1)) begin
      count_reg <= count_reg + CYC_W'(1);
    end
  end

  assign count = count_reg;

  // High during the last budgeted cycle, so the stop lands exactly after B cycles
  assign budget_hit = (budget != '0) && (count_reg == (budget - CYC_W'(1)));

endmodule

// File: rtl/boot_sequencer.sv
// Loads a program into the IF instruction memory, then releases and stops the core.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int CYC_W     = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       load_valid,
  input  logic [31:0]                load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  input  logic                       start,
  input  logic [CYC_W-1:0]           cycle_budget,
  input  logic [31:0]                Ins,
  output logic [31:0]                W_Ins,
  output logic                       WE,
  output logic [31:0]                newPC,
  output logic                       core_hold,
  output logic                       busy,
  output logic                       done,
  output logic                       halted,
  output logic                       overflow,
  output logic [$clog2(MAX_WORDS):0] word_count,
  output logic [CYC_W-1:0]           run_cycles
);

  localparam int WC_W = $clog2(MAX_WORDS) + 1;

  boot_state_t     state_reg;
  logic            load_ready_reg;
  logic            we_reg;
  logic [31:0]     w_ins_reg;
  logic [31:0]     new_pc_reg;
  logic            core_hold_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            halted_reg;
  logic            overflow_reg;
  logic [WC_W-1:0] word_count_reg;

  logic            xfer;
  logic            mem_full;
  logic            start_run;
  logic            in_run;
  logic            halt_now;
  logic            budget_hit;

  assign xfer      = load_valid && load_ready_reg;
  assign mem_full  = (word_count_reg == WC_W'(MAX_WORDS));
  assign in_run    = (state_reg == ST_RUN);
  assign halt_now  = is_halt(Ins);
  // A new load always takes priority over a start in the same cycle
  assign start_run = start && !load_valid &&
                     ((state_reg == ST_ARMED) || (state_reg == ST_DONE));

  boot_run_counter #(
    .CYC_W (CYC_W)
  ) u_run_counter (
    .clk        (CLK),
    .rst_n      (RST),
    .clr        (start_run),
    .en         (in_run),
    .budget     (cycle_budget),
    .count      (run_cycles),
    .budget_hit (budget_hit)
  );

  // Control FSM; every output is a register updated here
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg      <= ST_IDLE;
      load_ready_reg <= 1'b0;
      we_reg         <= 1'b0;
      w_ins_reg      <= '0;
      new_pc_reg     <= '0;
      core_hold_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      halted_reg     <= 1'b0;
      overflow_reg   <= 1'b0;
      word_count_reg <= '0;
    end else begin
      // Write strobe and address are single-cycle; ready is up outside RUN
      we_reg         <= 1'b0;
      new_pc_reg     <= '0;
      load_ready_reg <= 1'b1;
      case (state_reg)
        ST_IDLE, ST_ARMED, ST_DONE: begin
          if (xfer) begin
            // A fresh load always starts at word 0
            we_reg         <= 1'b1;
            w_ins_reg      <= load_data;
            new_pc_reg     <= '0;
            word_count_reg <= WC_W'(1);
            overflow_reg   <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= !load_last;
            state_reg      <= load_last ? ST_ARMED : ST_LOAD;
          end else if (start_run) begin
            state_reg      <= ST_RUN;
            core_hold_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            halted_reg     <= 1'b0;
            load_ready_reg <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (mem_full) begin
              // Memory is full: swallow the word so the host is not stalled
              overflow_reg <= 1'b1;
            end else begin
              we_reg         <= 1'b1;
              w_ins_reg      <= load_data;
              new_pc_reg     <= 32'(word_count_reg) << WORD_SHIFT;
              word_count_reg <= word_count_reg + WC_W'(1);
            end
            if (load_last) begin
              state_reg <= ST_ARMED;
              busy_reg  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (halt_now || budget_hit) begin
            state_reg     <= ST_DONE;
            core_hold_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            halted_reg    <= halt_now;
          end else begin
            load_ready_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign load_ready = load_ready_reg;
  assign WE         = we_reg;
  assign W_Ins      = w_ins_reg;
  assign newPC      = new_pc_reg;
  assign core_hold  = core_hold_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign halted     = halted_reg;
  assign overflow   = overflow_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed self-checking bench for boot_sequencer with a 4-word instruction memory.
module tb_boot_sequencer;

  localparam int TB_MAX = 4;
  localparam int TB_CYC = 16;

  logic              CLK;
  logic              RST;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_last;
  logic              load_ready;
  logic              start;
  logic [TB_CYC-1:0] cycle_budget;
  logic [31:0]       Ins;
  logic [31:0]       W_Ins;
  logic              WE;
  logic [31:0]       newPC;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              halted;
  logic              overflow;
  logic [2:0]        word_count;
  logic [TB_CYC-1:0] run_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] imem [0:7];
  logic [7:0]  pc;
  logic [31:0] we_addr_q [$];
  logic [31:0] we_data_q [$];
  int          low_cycles;

  boot_sequencer #(
    .MAX_WORDS (TB_MAX),
    .CYC_W     (TB_CYC)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .start        (start),
    .cycle_budget (cycle_budget),
    .Ins          (Ins),
    .W_Ins        (W_Ins),
    .WE           (WE),
    .newPC        (newPC),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .halted       (halted),
    .overflow     (overflow),
    .word_count   (word_count),
    .run_cycles   (run_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory of the IF stage: capture each write strobe
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      we_addr_q.push_back(newPC);
      we_data_q.push_back(W_Ins);
      if (newPC < 32'd32) imem[newPC[4:2]] <= W_Ins;
      $display("write   addr=%0d data=%h", newPC, W_Ins);
    end
  end

  // Minimal core: PC held at 0 in reset, one word per released cycle
  always @(posedge CLK) begin
    if (core_hold !== 1'b0) pc <= 8'd0;
    else                    pc <= pc + 8'd1;
  end

  assign Ins = ((core_hold !== 1'b0) || (pc > 8'd7)) ? 32'h0 : imem[pc[2:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic send_word(input logic [31:0] data, input logic last);
    int guard;
    guard      = 0;
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    while ((load_ready !== 1'b1) && (guard < 20)) begin
      @(posedge CLK); #1;
      guard++;
    end
    check_eq("ready_wait", 32'(guard < 20), 32'd1);
    @(posedge CLK); #1;
    $display("load    data=%h last=%0d word_count=%0d", data, last, word_count);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic run_prog(input logic [TB_CYC-1:0] budget, output int n_low);
    cycle_budget = budget;
    start        = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check_eq("released", 32'(core_hold), 32'd0);
    n_low = 0;
    while ((core_hold === 1'b0) && (n_low < 100)) begin
      @(posedge CLK); #1;
      n_low++;
    end
    $display("run     budget=%0d low_cycles=%0d run_cycles=%0d halted=%0d", budget, n_low, run_cycles, halted);
  endtask

  task automatic clear_q();
    we_addr_q.delete();
    we_data_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) imem[i] = 32'h0;
    RST = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    start = 1'b0; cycle_budget = '0;

    // Reset values
    @(posedge CLK); #1;
    check_eq("rst_load_ready", 32'(load_ready), 32'd0);
    check_eq("rst_we",         32'(WE),         32'd0);
    check_eq("rst_w_ins",      W_Ins,           32'd0);
    check_eq("rst_newpc",      newPC,           32'd0);
    check_eq("rst_core_hold",  32'(core_hold),  32'd1);
    check_eq("rst_busy",       32'(busy),       32'd0);
    check_eq("rst_done",       32'(done),       32'd0);
    check_eq("rst_flags",      {30'd0, halted, overflow}, 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    check_eq("rst_run_cycles", 32'(run_cycles), 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_eq("idle_ready", 32'(load_ready), 32'd1);

    // Three-word load ending in BREAK
    clear_q();
    send_word(32'h00221820, 1'b0);
    check_eq("load_busy", 32'(busy), 32'd1);
    send_word(32'h00000000, 1'b0);
    send_word(32'h0000000D, 1'b1);
    check_eq("armed_busy",  32'(busy),       32'd0);
    check_eq("armed_hold",  32'(core_hold),  32'd1);
    check_eq("armed_count", 32'(word_count), 32'd3);
    @(posedge CLK); #1;
    check_eq("we_count3", we_addr_q.size(), 32'd3);
    for (int i = 0; i < we_addr_q.size() && i < 3; i++) check_eq("we_addr3", we_addr_q[i], 32'(4 * i));
    if (we_data_q.size() == 3) check_eq("we_data_last", we_data_q[2], 32'h0000000D);
    check_eq("we_idle", 32'(WE), 32'd0);

    // Run until BREAK at PC 8
    run_prog('0, low_cycles);
    check_eq("brk_low_cycles", 32'(low_cycles), 32'd3);
    check_eq("brk_done",       32'(done),       32'd1);
    check_eq("brk_halted",     32'(halted),     32'd1);
    check_eq("brk_run_cycles", 32'(run_cycles), 32'd3);
    check_eq("brk_hold",       32'(core_hold),  32'd1);

    // No BREAK in program, budget of 5
    send_word(32'h00221820, 1'b0);
    send_word(32'h00000000, 1'b0);
    send_word(32'h00011020, 1'b0);
    send_word(32'h00000000, 1'b1);
    check_eq("bud_count", 32'(word_count), 32'd4);
    check_eq("bud_ovf",   32'(overflow),   32'd0);
    @(posedge CLK); #1;
    run_prog(16'd5, low_cycles);
    check_eq("bud_low_cycles", 32'(low_cycles), 32'd5);
    check_eq("bud_done",       32'(done),       32'd1);
    check_eq("bud_halted",     32'(halted),     32'd0);
    check_eq("bud_run_cycles", 32'(run_cycles), 32'd5);

    // Six words into a four-word memory
    clear_q();
    for (int i = 0; i < 6; i++) send_word(32'h100 + 32'(i), (i == 5));
    check_eq("ovf_flag",  32'(overflow),   32'd1);
    check_eq("ovf_count", 32'(word_count), 32'd4);
    check_eq("ovf_armed", {30'd0, busy, done}, 32'd0);
    @(posedge CLK); #1;
    check_eq("ovf_we_count", we_addr_q.size(), 32'd4);
    if (we_addr_q.size() == 4) begin
      check_eq("ovf_last_addr", we_addr_q[3], 32'd12);
      check_eq("ovf_last_data", we_data_q[3], 32'h103);
    end

    // Reset in the middle of an unbounded run
    cycle_budget = '0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_eq("mid_run_cycles", 32'(run_cycles), 32'd2);
    RST = 1'b0;
    @(posedge CLK); #1;
    check_eq("mrst_hold",  32'(core_hold),  32'd1);
    check_eq("mrst_busy",  32'(busy),       32'd0);
    check_eq("mrst_done",  32'(done),       32'd0);
    check_eq("mrst_rc",    32'(run_cycles), 32'd0);
    check_eq("mrst_ovf",   32'(overflow),   32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    check_eq("idle_start_hold", 32'(core_hold), 32'd1);
    check_eq("idle_start_busy", 32'(busy),      32'd0);
    $display("idle    start pulse ignored core_hold=%0d", core_hold);

    // Single-word BREAK program, then load and start together in DONE
    send_word(32'h0000000D, 1'b1);
    @(posedge CLK); #1;
    run_prog('0, low_cycles);
    check_eq("one_low_cycles", 32'(low_cycles), 32'd1);
    check_eq("one_run_cycles", 32'(run_cycles), 32'd1);
    check_eq("one_done",       32'(done),       32'd1);
    clear_q();
    load_valid = 1'b1; load_data = 32'h00221820; load_last = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    load_valid = 1'b0; start = 1'b0;
    $display("load    data=%h with start word_count=%0d", load_data, word_count);
    check_eq("race_busy",  32'(busy),       32'd1);
    check_eq("race_done",  32'(done),       32'd0);
    check_eq("race_hold",  32'(core_hold),  32'd1);
    check_eq("race_count", 32'(word_count), 32'd1);
    check_eq("race_rc",    32'(run_cycles), 32'd1);
    @(posedge CLK); #1;
    check_eq("race_we_count", we_addr_q.size(), 32'd1);
    if (we_addr_q.size() == 1) begin
      check_eq("race_addr", we_addr_q[0], 32'd0);
      check_eq("race_data", we_data_q[0], 32'h00221820);
    end
    check_eq("race_hold2", 32'(core_hold), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if something stalls the bench
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Boot and run controller for the single-clock MIPS core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into instruction memory through the IF write port (W_Ins/WE, address on newPC). It then holds the core in reset until `start`, releases it, and stops it again on a BREAK instruction or when a cycle budget expires. It sits between the host/testbench and the IF/ID/EX/MA chain.

## Interface
- MAX_WORDS, 64: instruction-memory capacity in words.
- CYC_W, 16: width of the cycle budget and run counter.
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-low reset; state is cleared on a CLK edge while RST==0.
- load_valid  in  1  host presents a program word.
- load_data  in  32  program word.
- load_last  in  1  qualifies the final word of the program.
- load_ready  out  1  block can accept a word.
- start  in  1  one-cycle pulse that begins or repeats execution.
- cycle_budget  in  CYC_W  maximum run cycles; 0 means run until halt.
- Ins  in  32  instruction currently fetched by IF (used for halt detection).
- W_Ins  out  32  IF write data.
- WE  out  1  IF instruction-memory write enable.
- newPC  out  32  IF write address (byte address) while loading; 0 otherwise.
- core_hold  out  1  drives the core's active-high reset; 1 holds the core.
- busy  out  1  high in LOAD or RUN.
- done  out  1  high in DONE.
- halted  out  1  the last run ended on BREAK (0 means it ended on budget).
- overflow  out  1  sticky flag: a word arrived beyond MAX_WORDS.
- word_count  out  $clog2(MAX_WORDS)+1  words accepted in the current load.
- run_cycles  out  CYC_W  cycles elapsed in the current or last run.

## Operation
- States: IDLE, LOAD, ARMED, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, load_ready 0 during the reset cycle, WE 0, W_Ins 0, newPC 0, core_hold 1, busy/done/halted/overflow 0, word_count 0, run_cycles 0.
- load_ready is 1 in IDLE, LOAD, ARMED and DONE, and 0 in RUN.
- IDLE/ARMED/DONE with load_valid: transfer the word and go to LOAD. The word counter restarts at 0, so the first word goes to address 0. overflow clears.
- LOAD: each transfer (valid & ready) registers W_Ins=load_data, newPC=word_count*4 and WE=1 for exactly one cycle, then increments word_count.
- Transfer with word_count==MAX_WORDS: the word is accepted and discarded. WE stays 0, overflow sets, word_count saturates.
- A transfer with load_last moves the block to ARMED.
- ARMED/DONE with start: run_cycles clears, halted clears, core_hold drops to 0 on the next edge, state goes to RUN.
- If start and load_valid arrive in the same cycle, load wins and start is ignored.
- RUN: run_cycles increments every cycle the core is released. Exit to DONE with core_hold=1 on the edge where either:
  - Ins == 32'h0000000D (BREAK); sets halted=1.
  - cycle_budget!=0 and run_cycles==cycle_budget-1; halted stays 0.
  - If both are true in the same cycle, halted=1.
- run_cycles saturates at all-ones and holds that value.
- start pulses while in RUN or LOAD are ignored.
- RST low in any state, including mid-load or mid-run, returns to reset values on that edge. Instruction memory contents are not cleared.

## Timing
- Load handshake: the WE pulse follows the accepting edge by one cycle. Back-to-back transfers give one write per cycle.
- Load to ARMED: ARMED is entered on the same edge that accepts load_last. The last WE is issued in the first ARMED cycle.
- Start latency: start sampled at edge N gives core_hold=0 after edge N. The core's first fetch (PC 0) happens at edge N+1.
- With budget B, the core runs exactly B cycles: core_hold returns to 1 after edge N+B.
- BREAK fetched in run cycle k: core_hold returns to 1 after that edge, and run_cycles reads k.

## Structure
- Package boot_seq_pkg holds:
  - state enum
  - BREAK_INS = 32'h0000000D
  - the halt function and opcode constants
  - word-to-byte shift (2)
- One sub-module, boot_run_counter: saturating CYC_W counter with clear and enable, plus a budget-compare output.
- Everything else is the FSM in boot_sequencer.

## Test plan
- Load 3 words (ADD $3,$1,$2 = 32'h00221820, 32'h00000000, 32'h0000000D) with load_last on the third. Expect three WE pulses at newPC 0, 4, 8, word_count=3, and ARMED with core_hold=1.
- start with budget=0 after that load: core released, BREAK fetched at PC 8. Expect done=1, halted=1, run_cycles=3, core_hold=1.
- Program with no BREAK, budget=5: expect exactly 5 cycles with core_hold=0, then done=1, halted=0, run_cycles=5.
- MAX_WORDS=4, stream 6 words: expect 4 WE pulses, overflow=1, word_count=4, then ARMED.
- RST=0 asserted mid-RUN at cycle 2: on the next edge expect IDLE, core_hold=1, run_cycles=0 and done=0. A start pulse then has no effect until a new load.
- In DONE, load_valid and start asserted in the same cycle: expect LOAD entered, the word written to newPC 0, and core_hold to stay 1.
